// File: rtl/tank_mover.sv
// tank_mover: per-frame movement update for a small set of artillery tanks.
// One tank is updated per step pulse. The update reads the heightmap under
// the tank, applies gravity / jump, then optionally probes the neighbouring
// column and slides sideways if that column is not a wall.
// Heightmap RAM has one cycle of read latency, so each probe takes two
// states (drive address, then consume data).

module tank_mover #(
    parameter int NUM_TANKS = 2,
    parameter int SCREEN_W  = 160,
    parameter int TANK_W    = 16,
    parameter int JUMP_MAX  = 20,
    parameter int FUEL_MAX  = 30,
    parameter int SPAWN_X0  = 5,
    parameter int SPAWN_DX  = 71,
    parameter int SPAWN_Y   = 110
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   step_i,
    input  logic [2:0]             active_i,
    input  logic                   move_left_i,
    input  logic                   move_right_i,
    input  logic                   jump_i,
    input  logic                   refuel_i,
    output logic [7:0]             hm_addr_o,
    input  logic [7:0]             hm_q_i,
    output logic [8*NUM_TANKS-1:0] tank_x_o,
    output logic [8*NUM_TANKS-1:0] tank_y_o,
    output logic [8*NUM_TANKS-1:0] fuel_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // Index width for the tank arrays; at least one bit so NUM_TANKS=1 works.
    localparam int         SW    = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam logic [3:0] NT4   = 4'(NUM_TANKS);
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - TANK_W);
    localparam logic [7:0] FUELV = 8'(FUEL_MAX);
    localparam logic [7:0] JUMPV = 8'(JUMP_MAX);

    typedef enum logic [2:0] {
        IDLE,
        RD_HERE,
        CHK_HERE,
        RD_NEXT,
        CHK_NEXT,
        FINISH
    } state_e;

    state_e state_q, state_d;

    // Per-tank state
    logic [NUM_TANKS-1:0][7:0] x_q,    x_d;
    logic [NUM_TANKS-1:0][7:0] y_q,    y_d;
    logic [NUM_TANKS-1:0][7:0] fuel_q, fuel_d;
    logic [NUM_TANKS-1:0][7:0] cap_q,  cap_d;

    // Step context latched when the step is accepted
    logic [SW-1:0] sel_q,   sel_d;
    logic          left_q,  left_d;
    logic          right_q, right_d;
    logic          jump_q,  jump_d;
    logic [7:0]    tgt_q,   tgt_d;
    logic [7:0]    hm_addr_q, hm_addr_d;
    logic          pend_q,  pend_d;

    // Datapath intermediates
    logic [SW-1:0] sel_in;
    logic [7:0]    cur_x, cur_y, cur_f, cur_c;
    logic [7:0]    vy, vf, vc;
    logic [7:0]    tgt;
    logic          h_ok;

    // Out-of-range tank indices fall back to tank 0.
    always_comb begin
        sel_in = '0;
        if ({1'b0, active_i} < NT4)
            sel_in = active_i[SW-1:0];
    end

    // Vertical rule and horizontal eligibility for the selected tank.
    // Only consumed in CHK_HERE, where hm_q_i holds the ground under the tank.
    always_comb begin
        cur_x = x_q[sel_q];
        cur_y = y_q[sel_q];
        cur_f = fuel_q[sel_q];
        cur_c = cap_q[sel_q];
        vy    = cur_y;
        vf    = cur_f;
        vc    = cur_c;
        if (jump_q && cur_c != 8'd0 && cur_f != 8'd0 && cur_y != 8'd0) begin
            // Rise one pixel, burning jump capacity and fuel.
            vy = cur_y - 8'd1;
            vc = cur_c - 8'd1;
            vf = cur_f - 8'd1;
        end else if (cur_y < hm_q_i) begin
            // Airborne: fall one pixel, no more lift until landing.
            vy = cur_y + 8'd1;
            vc = 8'd0;
        end else if (cur_y == hm_q_i && !jump_q) begin
            // Standing still on the ground recharges the jump.
            vc = JUMPV;
        end
        // Both directions pressed cancel out; fuel is checked after any jump.
        tgt  = left_q ? (cur_x - 8'd1) : (cur_x + 8'd1);
        h_ok = (left_q ^ right_q) && (vf != 8'd0) &&
               (left_q ? (cur_x != 8'd0) : (cur_x < X_MAX));
    end

    // Next-state and update logic for the step sequencer.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        fuel_d    = fuel_q;
        cap_d     = cap_q;
        sel_d     = sel_q;
        left_d    = left_q;
        right_d   = right_q;
        jump_d    = jump_q;
        tgt_d     = tgt_q;
        hm_addr_d = hm_addr_q;
        pend_d    = pend_q;

        // A refuel that lands mid-update is held until the update closes.
        if (refuel_i && state_q != IDLE && state_q != FINISH)
            pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (refuel_i) begin
                    for (int i = 0; i < NUM_TANKS; i++)
                        fuel_d[i] = FUELV;
                end
                if (step_i) begin
                    sel_d     = sel_in;
                    left_d    = move_left_i;
                    right_d   = move_right_i;
                    jump_d    = jump_i;
                    hm_addr_d = x_q[sel_in];
                    state_d   = RD_HERE;
                end
            end
            RD_HERE: begin
                state_d = CHK_HERE;
            end
            CHK_HERE: begin
                y_d[sel_q]    = vy;
                fuel_d[sel_q] = vf;
                cap_d[sel_q]  = vc;
                if (h_ok) begin
                    tgt_d     = tgt;
                    hm_addr_d = tgt;
                    state_d   = RD_NEXT;
                end else begin
                    state_d   = FINISH;
                end
            end
            RD_NEXT: begin
                state_d = CHK_NEXT;
            end
            CHK_NEXT: begin
                // Slide only if the neighbour's ground is not above us.
                if (hm_q_i >= cur_y) begin
                    x_d[sel_q] = tgt_q;
                    if (cur_f != 8'd0)
                        fuel_d[sel_q] = cur_f - 8'd1;
                end
                state_d = FINISH;
            end
            FINISH: begin
                // Deferred (or same-cycle) refuel overrides the step's fuel.
                if (pend_q || refuel_i) begin
                    for (int i = 0; i < NUM_TANKS; i++)
                        fuel_d[i] = FUELV;
                end
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset restores spawn positions and full resources.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            jump_q    <= 1'b0;
            tgt_q     <= 8'd0;
            hm_addr_q <= 8'd0;
            pend_q    <= 1'b0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                x_q[i]    <= 8'(SPAWN_X0 + i * SPAWN_DX);
                y_q[i]    <= 8'(SPAWN_Y);
                fuel_q[i] <= FUELV;
                cap_q[i]  <= JUMPV;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            left_q    <= left_d;
            right_q   <= right_d;
            jump_q    <= jump_d;
            tgt_q     <= tgt_d;
            hm_addr_q <= hm_addr_d;
            pend_q    <= pend_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fuel_q    <= fuel_d;
            cap_q     <= cap_d;
        end
    end

    assign hm_addr_o = hm_addr_q;
    assign tank_x_o  = x_q;
    assign tank_y_o  = y_q;
    assign fuel_o    = fuel_q;
    assign busy_o    = (state_q == RD_HERE) || (state_q == CHK_HERE) ||
                       (state_q == RD_NEXT) || (state_q == CHK_NEXT);
    assign done_o    = (state_q == FINISH);

endmodule

// File: doc/tank_mover.md
TANK_MOVER -- requirements
Module: tank_mover

Interface
REQ-001 Param NUM_TANKS, default 2: tanks managed; 1..8.
REQ-002 Param SCREEN_W, default 160: screen width in pixels.
REQ-003 Param TANK_W, default 16: tank width; max x = SCREEN_W-TANK_W.
REQ-004 Param JUMP_MAX, default 20: jump capacity restored on ground.
REQ-005 Param FUEL_MAX, default 30: fuel per turn.
REQ-006 Param SPAWN_X0 / SPAWN_DX / SPAWN_Y, defaults 5 / 71 / 110: reset position of tank i = (SPAWN_X0+i*SPAWN_DX, SPAWN_Y).
REQ-007 clock  in  1  system clock (CLOCK_50); one clock domain, all state on rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 step  in  1  one-cycle frame pulse; starts one update.
REQ-010 active  in  3  index of the tank moved this step.
REQ-011 move_left, move_right, jump  in  1 each  active-high controls, sampled on the step cycle.
REQ-012 refuel  in  1  pulse; restores fuel of all tanks.
REQ-013 hm_addr  out  8  heightmap RAM read address (x column).
REQ-014 hm_q  in  8  heightmap data (ground y at hm_addr); valid exactly 1 cycle after hm_addr.
REQ-015 tank_x, tank_y  out  8*NUM_TANKS each  packed positions; tank i at bits [8i+7:8i].
REQ-016 fuel  out  8*NUM_TANKS  packed remaining fuel.
REQ-017 busy  out  1  high from the cycle after an accepted step until done.
REQ-018 done  out  1  one-cycle pulse when an update completes.

Function
REQ-019 y grows downward; tank on ground when y == ground; a column is reachable if its ground >= current y.
REQ-020 FSM states: IDLE, RD_HERE, CHK_HERE, RD_NEXT, CHK_NEXT, FINISH.
REQ-021 IDLE: on step, latch controls and active (active >= NUM_TANKS treated as 0), drive hm_addr = x[sel], busy=1 -> RD_HERE.
REQ-022 RD_HERE: wait for RAM latency -> CHK_HERE.
REQ-023 CHK_HERE vertical, first match wins: (a) jump && cap>0 && fuel>0 && y>0: y-=1, cap-=1, fuel-=1; (b) y<ground: y+=1, cap=0; (c) y==ground && !jump: cap=JUMP_MAX; (d) else no change.
REQ-024 CHK_HERE horizontal: exactly one of left/right, fuel>0 after vertical update, and target in [0, SCREEN_W-TANK_W]: hm_addr = x±1 -> RD_NEXT; otherwise -> FINISH.
REQ-025 Left and right both asserted: no horizontal move, no fuel spent.
REQ-026 RD_NEXT -> CHK_NEXT; if hm_q >= y (y after vertical update) then x=target, fuel-=1; -> FINISH.
REQ-027 FINISH: done=1 for one cycle, busy=0 -> IDLE; total latency step-to-done 5 cycles with move, 3 without.
REQ-028 step while busy: ignored, no queueing.
REQ-029 refuel in IDLE: fuel[i]=FUEL_MAX for all i; refuel while busy: deferred until FINISH, applied on that cycle after the step's own update; refuel and step same cycle in IDLE: refuel applied, step accepted.
REQ-030 fuel never underflows; all arithmetic saturating at 0 and 255; other tanks never change during a step.
REQ-031 Jump capacity is per tank, 8 bits, reset to JUMP_MAX.

Reset
REQ-032 reset overrides everything, incl. mid-update: state=IDLE, busy=0, done=0, hm_addr=0, positions to spawn, fuel=FUEL_MAX, cap=JUMP_MAX, deferred refuel cleared.

Verification
REQ-033 Flat ground 110, tank0 at (5,110), step+right -> done after 5 cycles, x=6, y=110, fuel=29.
REQ-034 Tank0 at x=20, column 21 ground 104, y=110, step+right -> x unchanged, fuel=30, done after 5 cycles.
REQ-035 Tank0 on ground, hold jump 25 steps -> y decreases 20 steps to 90, then falls 1/step; fuel=10 after 20 jumps.
REQ-036 fuel=1, step+jump+right on flat ground -> y-=1, fuel=0, no horizontal move, done after 3 cycles.
REQ-037 Step then step again 2 cycles later, plus refuel during busy -> second step ignored, fuel=FUEL_MAX after done.
REQ-038 Assert reset in RD_NEXT -> next cycle busy=0, all tanks at spawn, fuel=30, no done pulse.
